// File: rtl/dual_port_memory.sv
// rtl/dual_port_memory.sv - true dual-port synchronous RAM, registered read-first outputs
//
// Purpose:
//   2**ADDR x DATA storage with two independent read/write ports on one clock.
//   Both ports read on every clock edge and show the data one cycle later.
//   By default reads return the contents from before that edge's writes.
//   If both ports write one address in the same cycle, port A's data is kept.
//
// Build option:
//   MEMORY_WRITE_FORWARD_EN - when defined, a port that reads an address
//   being written in the same cycle (by either port) returns the new data.
//   Port A's data takes precedence when both ports write that address.
//   Array write behaviour is the same in both builds.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset; clears a_dout/b_dout and blocks writes
//   a_wr    in   port A write enable
//   a_addr  in   port A address [ADDR-1:0]
//   a_din   in   port A write data [DATA-1:0]
//   a_dout  out  port A registered read data [DATA-1:0]
//   b_wr    in   port B write enable
//   b_addr  in   port B address [ADDR-1:0]
//   b_din   in   port B write data [DATA-1:0]
//   b_dout  out  port B registered read data [DATA-1:0]

module dual_port_memory #(
  parameter int ADDR = 4,
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_wr,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  output logic [DATA-1:0] a_dout,
  input  logic            b_wr,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout
);

  localparam int DEPTH = 1 << ADDR;

  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] a_rd;
  logic [DATA-1:0] b_rd;

  // The array has no reset, so its contents survive rst_n.
  // rst_n is still tested here so that no write can land while reset is held.
  // Port B's write is issued first and port A's second.
  // On an address collision the later assignment (port A) is the one that sticks.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (b_wr == 1'b1) begin
        mem[b_addr] <= b_din;
      end
      if (a_wr == 1'b1) begin
        mem[a_addr] <= a_din;
      end
    end
  end

  // Select the next read word for each port.
  always_comb begin
    a_rd = mem[a_addr];
    b_rd = mem[b_addr];
`ifdef MEMORY_WRITE_FORWARD_EN
    // Port B is checked first so that port A's data overrides it on a double write.
    if (b_wr == 1'b1 && b_addr == a_addr) begin
      a_rd = b_din;
    end
    if (a_wr == 1'b1) begin
      a_rd = a_din;
    end
    if (b_wr == 1'b1) begin
      b_rd = b_din;
    end
    if (a_wr == 1'b1 && a_addr == b_addr) begin
      b_rd = a_din;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= a_rd;
      b_dout <= b_rd;
    end
  end

endmodule

// File: tb/tb_dual_port_memory.sv
// tb/tb_dual_port_memory.sv - directed table-driven bench for dual_port_memory

module tb_dual_port_memory;

`ifdef MEMORY_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_wr;
  logic [3:0] a_addr;
  logic [7:0] a_din;
  logic [7:0] a_dout;
  logic       b_wr;
  logic [3:0] b_addr;
  logic [7:0] b_din;
  logic [7:0] b_dout;

  int n_chk = 0;
  int n_bad = 0;

  dual_port_memory #(.ADDR(4), .DATA(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_wr   (a_wr),
    .a_addr (a_addr),
    .a_din  (a_din),
    .a_dout (a_dout),
    .b_wr   (b_wr),
    .b_addr (b_addr),
    .b_din  (b_din),
    .b_dout (b_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = inputs for one clock edge plus the dout values expected right after it.
  typedef struct {
    logic       a_wr;
    logic [3:0] a_addr;
    logic [7:0] a_din;
    logic       b_wr;
    logic [3:0] b_addr;
    logic [7:0] b_din;
    bit         ca;
    logic [7:0] ea;
    bit         cb;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic aw, logic [3:0] aa, logic [7:0] ad,
                              logic bw, logic [3:0] ba, logic [7:0] bd,
                              bit ca, logic [7:0] ea, bit cb, logic [7:0] eb);
    vec_t v;
    v.a_wr = aw; v.a_addr = aa; v.a_din = ad;
    v.b_wr = bw; v.b_addr = ba; v.b_din = bd;
    v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                       input logic bw, input logic [3:0] ba, input logic [7:0] bd);
    a_wr = aw; a_addr = aa; a_din = ad;
    b_wr = bw; b_addr = ba; b_din = bd;
  endtask

  initial begin
    // Reset is held for 5 cycles while a write is attempted.
    rst_n = 1'b0;
    drive(1'b1, 4'd3, 8'h77, 1'b1, 4'd15, 8'h66);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_a_%0d", i), a_dout, 8'h00);
      check($sformatf("reset_b_%0d", i), b_dout, 8'h00);
    end
    rst_n = 1'b1;
    drive(1'b0, 4'd3, 8'h00, 1'b0, 4'd15, 8'h00);
    #2;
    check("post_release_a", a_dout, 8'h00);
    check("post_release_b", b_dout, 8'h00);

    // Columns: a_wr a_addr a_din  b_wr b_addr b_din  ca exp_a  cb exp_b
    tbl.push_back(mk(1, 4'd3,  8'd234, 0, 4'd0,  8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 4'd4,  8'd222, 0, 4'd0,  8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 4'd3,  8'h00,  0, 4'd4,  8'h00, 1, 8'd234, 1, 8'd222));
    tbl.push_back(mk(0, 4'd4,  8'h00,  0, 4'd3,  8'h00, 1, 8'd222, 1, 8'd234));
    tbl.push_back(mk(1, 4'd3,  8'd234, 1, 4'd15, 8'd255, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 4'd15, 8'h00,  0, 4'd3,  8'h00, 1, 8'd255, 1, 8'd234));
    tbl.push_back(mk(1, 4'd0,  8'd1,   0, 4'd3,  8'h00, 0, 8'h00, 1, 8'd234));
    tbl.push_back(mk(0, 4'd0,  8'h00,  0, 4'd0,  8'h00, 1, 8'd1, 1, 8'd1));
    tbl.push_back(mk(1, 4'd7,  8'h11,  1, 4'd7,  8'h22, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 4'd7,  8'h00,  0, 4'd7,  8'h00, 1, 8'h11, 1, 8'h11));
    tbl.push_back(mk(1, 4'd5,  8'h33,  0, 4'd7,  8'h00, 0, 8'h00, 1, 8'h11));
    // A writes 5 while both ports read 5.
    tbl.push_back(mk(1, 4'd5,  8'h44,  0, 4'd5,  8'h00,
                     1, FWD ? 8'h44 : 8'h33, 1, FWD ? 8'h44 : 8'h33));
    tbl.push_back(mk(0, 4'd5,  8'h00,  0, 4'd5,  8'h00, 1, 8'h44, 1, 8'h44));
    // A writes 3 while B reads 3.
    tbl.push_back(mk(1, 4'd3,  8'h99,  0, 4'd3,  8'h00,
                     1, FWD ? 8'h99 : 8'd234, 1, FWD ? 8'h99 : 8'd234));
    // B writes 15 while A reads 15.
    tbl.push_back(mk(0, 4'd15, 8'h00,  1, 4'd15, 8'hAB,
                     1, FWD ? 8'hAB : 8'd255, 1, FWD ? 8'hAB : 8'd255));
    tbl.push_back(mk(0, 4'd15, 8'h00,  0, 4'd3,  8'h00, 1, 8'hAB, 1, 8'h99));
    tbl.push_back(mk(1, 4'd8,  8'h01,  0, 4'd3,  8'h00, 0, 8'h00, 1, 8'h99));
    // Both ports write 8: port A has priority, including for the forwarded data.
    tbl.push_back(mk(1, 4'd8,  8'h5C,  1, 4'd8,  8'hC5,
                     1, FWD ? 8'h5C : 8'h01, 1, FWD ? 8'h5C : 8'h01));
    tbl.push_back(mk(0, 4'd8,  8'h00,  0, 4'd8,  8'h00, 1, 8'h5C, 1, 8'h5C));
    // A write enable of X must not write.
    tbl.push_back(mk(1'bx, 4'd8, 8'hFF, 0, 4'd8, 8'h00, 1, 8'h5C, 1, 8'h5C));
    tbl.push_back(mk(0, 4'd8,  8'h00,  0, 4'd8,  8'h00, 1, 8'h5C, 1, 8'h5C));
    // All-ones data is stored at full width.
    tbl.push_back(mk(0, 4'd2,  8'h00,  1, 4'd2,  8'hFF, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 4'd2,  8'h00,  0, 4'd2,  8'h00, 1, 8'hFF, 1, 8'hFF));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].a_wr, tbl[i].a_addr, tbl[i].a_din,
            tbl[i].b_wr, tbl[i].b_addr, tbl[i].b_din);
      @(posedge clk); #1;
      if (tbl[i].ca) check($sformatf("vec%0d_a", i), a_dout, tbl[i].ea);
      if (tbl[i].cb) check($sformatf("vec%0d_b", i), b_dout, tbl[i].eb);
    end

    // Reset asserted mid-operation: outputs clear at once, writes are ignored, and contents are kept.
    drive(1'b1, 4'd9, 8'h12, 1'b0, 4'd2, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 4'd9, 8'h00, 1'b0, 4'd9, 8'h00);
    @(posedge clk); #1;
    check("pre_reset_a", a_dout, 8'h12);
    check("pre_reset_b", b_dout, 8'h12);
    #2;
    rst_n = 1'b0;
    drive(1'b1, 4'd9, 8'hEE, 1'b1, 4'd9, 8'hDD);
    #1;
    check("async_clear_a", a_dout, 8'h00);
    check("async_clear_b", b_dout, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_reset_a_%0d", i), a_dout, 8'h00);
      check($sformatf("mid_reset_b_%0d", i), b_dout, 8'h00);
    end
    rst_n = 1'b1;
    drive(1'b0, 4'd9, 8'h00, 1'b0, 4'd9, 8'h00);
    #1;
    check("release_hold_a", a_dout, 8'h00);
    @(posedge clk); #1;
    check("kept_across_reset_a", a_dout, 8'h12);
    check("kept_across_reset_b", b_dout, 8'h12);
    // dout holds its value between edges.
    #3;
    check("hold_a", a_dout, 8'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
